io_sched: RTL and testbench
===========================

Name: io_sched

Overview:
Port scheduler between external sample streams and the float processor's decoded I/O strobes. It buffers NUIOIN input streams in per-channel FIFOs and delivers the addressed head word when the processor asserts its one-hot req_in. It captures processor results on one-hot out_en into per-channel output registers with a valid/ready handshake. It sits outside the int2float/float2int wrapper, on the integer side.

Parameters:
NBIN, 19, input sample width (signed)
NBOUT, 28, output sample width (signed)
NUIOIN, 4, number of input channels
NUIOOU, 4, number of output channels
FDEPTH, 4, input FIFO depth per channel; power of two, >=2

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
s_data  in  NUIOIN*NBIN  input samples; channel k at bits [k*NBIN +: NBIN]
s_valid  in  NUIOIN  per-channel input valid
s_ready  out  NUIOIN  per-channel input ready
io_in  out  NBIN  word presented to the processor input path
req_in  in  NUIOIN  one-hot processor read strobe (decoded)
io_out  in  NBOUT  processor output word
out_en  in  NUIOOU  one-hot processor write strobe (decoded)
m_data  out  NUIOOU*NBOUT  captured results, channel k at [k*NBOUT +: NBOUT]
m_valid  out  NUIOOU  per-channel result valid
m_ready  in  NUIOOU  per-channel result accept
clr_flags  in  1  synchronous clear of sticky flags
underflow  out  NUIOIN  sticky: read of an empty FIFO
overflow  out  NUIOOU  sticky: unaccepted result overwritten
sel_err  out  1  sticky: req_in or out_en had more than one bit set
in_cnt  out  NUIOIN*16  per-channel delivered-word count (optional feature)

Behaviour:
- Reset (rst=0, async): all FIFOs empty, m_valid=0, m_data=0, all flags=0, in_cnt=0. s_ready=1 on all channels. io_in=0.
- Input FIFO per channel: counter 0..FDEPTH, read and write pointers wrap modulo FDEPTH.
  - s_ready[k] = !full[k]. It is registered-state only, with no combinational path from req_in.
  - Push when s_valid[k]&s_ready[k].
- Processor read: io_in is combinational, equal to the head of the FIFO selected by one-hot req_in. It is valid in the same cycle the strobe is asserted, and the pop occurs at that clock edge.
  - req_in=0: io_in=0, no pop.
  - Addressed FIFO empty: io_in=0, no pop, underflow[k] set next cycle.
  - More than one req_in bit set: io_in=0, no pop, sel_err set.
  - Simultaneous push and pop on the same channel: count unchanged.
  - Simultaneous push and pop on an empty channel: pop refused (underflow), push succeeds, count becomes 1.
- Output channel state machine, per channel: EMPTY(m_valid=0) / FULL(m_valid=1).
  - EMPTY + out_en[k]: load io_out, go FULL.
  - FULL + m_ready[k] without out_en[k]: go EMPTY. m_data holds its value.
  - FULL + out_en[k] + m_ready[k]: load new word, stay FULL, no overflow.
  - FULL + out_en[k] without m_ready[k]: overwrite (latest wins), overflow[k] set.
  - out_en with more than one bit set: no capture, sel_err set.
- Sticky flags:
  - Set one cycle after the event.
  - clr_flags clears all flags.
  - If a new event and clr_flags occur in the same cycle, set wins.
- Latency:
  - Input: a word pushed at edge N is readable by req_in in cycle N+1.
  - Output: out_en at edge N gives m_valid=1 from N+1.
- Reset mid-operation: FIFO contents discarded; pending results dropped without flag.

Optional Feature:
Macro IO_SCHED_CNT_EN.
- Defined: in_cnt[k] is a 16-bit counter incremented on each successful pop of channel k. It saturates at 16'hFFFF and is cleared by clr_flags and by reset.
- Undefined: no counter logic is built, and in_cnt is tied to 0.

Test Plan:
- Reset then fill: push 4 words into ch0 (1,2,3,4) → s_ready[0]=0 after the 4th push; a 5th s_valid is held off and the word is not lost once ready.
- Read order: req_in=4'b0001 for 4 cycles → io_in=1,2,3,4 in successive cycles, then ch0 empty.
- Underflow: req_in=4'b0100 with ch2 empty → io_in=0, underflow=4'b0100 next cycle. Assert clr_flags → underflow=0.
- Empty push and pop: ch1 empty, push 7 and req_in=4'b0010 in the same cycle → underflow[1]=1, count=1, next req returns 7.
- Output overwrite: out_en=4'b1000 with io_out=100, then io_out=200 with m_ready[3]=0 → m_data ch3=200, overflow[3]=1. Repeat with m_ready=1 → no overflow.
- Select error: req_in=4'b0011 → io_in=0, no pops, sel_err=1. With IO_SCHED_CNT_EN, in_cnt after 3 good reads on ch0 is 3.

Source files
------------

// File: rtl/io_sched_if.sv
// rtl/io_sched_if.sv - stream, processor strobe and result handshake bundle for io_sched
interface io_sched_if #(
    parameter int NBIN   = 19,
    parameter int NBOUT  = 28,
    parameter int NUIOIN = 4,
    parameter int NUIOOU = 4
);
    logic [NUIOIN*NBIN-1:0]  s_data;
    logic [NUIOIN-1:0]       s_valid;
    logic [NUIOIN-1:0]       s_ready;
    logic [NBIN-1:0]         io_in;
    logic [NUIOIN-1:0]       req_in;
    logic [NBOUT-1:0]        io_out;
    logic [NUIOOU-1:0]       out_en;
    logic [NUIOOU*NBOUT-1:0] m_data;
    logic [NUIOOU-1:0]       m_valid;
    logic [NUIOOU-1:0]       m_ready;

    modport master (
        output s_data, s_valid, req_in, io_out, out_en, m_ready,
        input  s_ready, io_in, m_data, m_valid
    );

    modport slave (
        input  s_data, s_valid, req_in, io_out, out_en, m_ready,
        output s_ready, io_in, m_data, m_valid
    );
endinterface

// File: rtl/io_sched.sv
// rtl/io_sched.sv - per-channel input FIFOs and output result registers for the float processor I/O strobes
// Optional delivered-word counters enabled by IO_SCHED_CNT_EN.
module io_sched #(
    parameter int NBIN   = 19,
    parameter int NBOUT  = 28,
    parameter int NUIOIN = 4,
    parameter int NUIOOU = 4,
    parameter int FDEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    io_sched_if.slave           bus,
    input  logic                clr_flags,
    output logic [NUIOIN-1:0]   underflow,
    output logic [NUIOOU-1:0]   overflow,
    output logic                sel_err,
    output logic [NUIOIN*16-1:0] in_cnt
);
    localparam int AW = $clog2(FDEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(FDEPTH);

    typedef enum logic {OUT_EMPTY = 1'b0, OUT_FULL = 1'b1} out_state_t;

    logic [NBIN-1:0]  mem    [NUIOIN][FDEPTH];
    logic [AW-1:0]    wr_ptr [NUIOIN];
    logic [AW-1:0]    rd_ptr [NUIOIN];
    logic [AW:0]      fcnt   [NUIOIN];

    logic [NUIOIN-1:0] full, push, pop, uf_evt;
    logic              req_multi, req_one, out_multi, out_one;
    logic [NBIN-1:0]   io_in_w;

    out_state_t        out_state [NUIOOU];
    out_state_t        out_next  [NUIOOU];
    logic [NUIOOU-1:0] cap, ov_evt, m_valid_w;
    logic [NUIOOU*NBOUT-1:0] m_data_r;

    // A strobe is honoured only when exactly one bit is set; x & (x-1) is nonzero for two or more.
    always_comb begin
        req_multi = |(bus.req_in & (bus.req_in - NUIOIN'(1)));
        req_one   = (bus.req_in != '0) && !req_multi;
        out_multi = |(bus.out_en & (bus.out_en - NUIOOU'(1)));
        out_one   = (bus.out_en != '0) && !out_multi;
    end

    always_comb begin
        io_in_w = '0;
        for (int k = 0; k < NUIOIN; k++) begin
            full[k]   = (fcnt[k] == FULL_CNT);
            push[k]   = bus.s_valid[k] && !full[k];
            pop[k]    = bus.req_in[k] && req_one && (fcnt[k] != '0);
            uf_evt[k] = bus.req_in[k] && req_one && (fcnt[k] == '0);
            if (pop[k]) begin
                io_in_w = mem[k][rd_ptr[k]];
            end
        end
    end

    assign bus.s_ready = ~full;
    assign bus.io_in   = io_in_w;

    always_ff @(posedge clk) begin
        for (int k = 0; k < NUIOIN; k++) begin
            if (push[k]) begin
                mem[k][wr_ptr[k]] <= bus.s_data[k*NBIN +: NBIN];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < NUIOIN; k++) begin
                wr_ptr[k] <= '0;
                rd_ptr[k] <= '0;
                fcnt[k]   <= '0;
            end
        end else begin
            for (int k = 0; k < NUIOIN; k++) begin
                if (push[k]) wr_ptr[k] <= wr_ptr[k] + AW'(1);
                if (pop[k])  rd_ptr[k] <= rd_ptr[k] + AW'(1);
                case ({push[k], pop[k]})
                    2'b10:   fcnt[k] <= fcnt[k] + (AW+1)'(1);
                    2'b01:   fcnt[k] <= fcnt[k] - (AW+1)'(1);
                    default: fcnt[k] <= fcnt[k];
                endcase
            end
        end
    end

    // Result channels: a fresh capture always wins; it only counts as overflow if the old word went unaccepted.
    always_comb begin
        for (int k = 0; k < NUIOOU; k++) begin
            cap[k]       = bus.out_en[k] && out_one;
            out_next[k]  = out_state[k];
            ov_evt[k]    = 1'b0;
            m_valid_w[k] = (out_state[k] == OUT_FULL);
            case (out_state[k])
                OUT_EMPTY: begin
                    if (cap[k]) out_next[k] = OUT_FULL;
                end
                OUT_FULL: begin
                    if (cap[k]) begin
                        ov_evt[k] = !bus.m_ready[k];
                    end else if (bus.m_ready[k]) begin
                        out_next[k] = OUT_EMPTY;
                    end
                end
                default: out_next[k] = OUT_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < NUIOOU; k++) out_state[k] <= OUT_EMPTY;
            m_data_r <= '0;
        end else begin
            for (int k = 0; k < NUIOOU; k++) begin
                out_state[k] <= out_next[k];
                if (cap[k]) m_data_r[k*NBOUT +: NBOUT] <= bus.io_out;
            end
        end
    end

    assign bus.m_data  = m_data_r;
    assign bus.m_valid = m_valid_w;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            underflow <= '0;
            overflow  <= '0;
            sel_err   <= 1'b0;
        end else begin
            underflow <= (underflow & ~{NUIOIN{clr_flags}}) | uf_evt;
            overflow  <= (overflow & ~{NUIOOU{clr_flags}}) | ov_evt;
            sel_err   <= (sel_err & !clr_flags) | req_multi | out_multi;
        end
    end

`ifdef IO_SCHED_CNT_EN
    logic [15:0] cnt_r [NUIOIN];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < NUIOIN; k++) cnt_r[k] <= '0;
        end else begin
            for (int k = 0; k < NUIOIN; k++) begin
                if (clr_flags) begin
                    cnt_r[k] <= '0;
                end else if (pop[k] && cnt_r[k] != 16'hFFFF) begin
                    cnt_r[k] <= cnt_r[k] + 16'd1;
                end
            end
        end
    end

    always_comb begin
        for (int k = 0; k < NUIOIN; k++) in_cnt[k*16 +: 16] = cnt_r[k];
    end
`else
    assign in_cnt = '0;
`endif
endmodule

// File: tb/tb_io_sched.sv
// tb/tb_io_sched.sv - scoreboard bench for io_sched with directed vectors
module tb_io_sched;
    localparam int NBIN   = 19;
    localparam int NBOUT  = 28;
    localparam int NUIOIN = 4;
    localparam int NUIOOU = 4;
    localparam int FDEPTH = 4;
`ifdef IO_SCHED_CNT_EN
    localparam int CNT_ON = 1;
`else
    localparam int CNT_ON = 0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    io_sched_if #(.NBIN(NBIN), .NBOUT(NBOUT), .NUIOIN(NUIOIN), .NUIOOU(NUIOOU)) bus ();

    logic                 clr_flags;
    logic [NUIOIN-1:0]    underflow;
    logic [NUIOOU-1:0]    overflow;
    logic                 sel_err;
    logic [NUIOIN*16-1:0] in_cnt;

    io_sched #(.NBIN(NBIN), .NBOUT(NBOUT), .NUIOIN(NUIOIN), .NUIOOU(NUIOOU), .FDEPTH(FDEPTH)) dut (
        .clk       (clk),
        .rst       (rst_n),
        .bus       (bus.slave),
        .clr_flags (clr_flags),
        .underflow (underflow),
        .overflow  (overflow),
        .sel_err   (sel_err),
        .in_cnt    (in_cnt)
    );

    typedef struct {
        int              ch;
        logic [NBOUT-1:0] data;
    } out_exp_t;

    int n_assert = 0;
    int n_fail   = 0;
    logic [NBIN-1:0] exp_in_q [$];
    out_exp_t        exp_out_q [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every processor read and every accepted result is matched against the scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.req_in != '0) begin
                if (exp_in_q.size() == 0) begin
                    n_assert++;
                    n_fail++;
                    $display("FAIL io_in_unexpected: got %0h expected none", bus.io_in);
                end else begin
                    check("io_in", 64'(bus.io_in), 64'(exp_in_q[0]));
                    void'(exp_in_q.pop_front());
                end
            end
            for (int k = 0; k < NUIOOU; k++) begin
                if (bus.m_valid[k] && bus.m_ready[k]) begin
                    if (exp_out_q.size() == 0) begin
                        n_assert++;
                        n_fail++;
                        $display("FAIL m_data_unexpected: ch %0d got %0h expected none", k, bus.m_data[k*NBOUT +: NBOUT]);
                    end else begin
                        check("m_ch", 64'(k), 64'(exp_out_q[0].ch));
                        check("m_data", 64'(bus.m_data[k*NBOUT +: NBOUT]), 64'(exp_out_q[0].data));
                        void'(exp_out_q.pop_front());
                    end
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic exp_out(input int ch, input logic [NBOUT-1:0] d);
        out_exp_t e;
        e.ch = ch;
        e.data = d;
        exp_out_q.push_back(e);
    endtask

    task automatic clear_flags;
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
    endtask

    initial begin
        bus.s_data  = '0;
        bus.s_valid = '0;
        bus.req_in  = '0;
        bus.io_out  = '0;
        bus.out_en  = '0;
        bus.m_ready = '0;
        clr_flags   = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_s_ready", 64'(bus.s_ready), 64'hF);
        check("rst_m_valid", 64'(bus.m_valid), 64'h0);
        check("rst_m_data", 64'(bus.m_data[63:0]), 64'h0);
        check("rst_io_in", 64'(bus.io_in), 64'h0);
        check("rst_flags", 64'({underflow, overflow, sel_err}), 64'h0);
        check("rst_in_cnt", in_cnt, 64'h0);
        rst_n = 1'b1;
        tick();

        // Fill ch0 to capacity, then hold a fifth word against backpressure.
        for (int i = 1; i <= 4; i++) begin
            bus.s_valid[0] = 1'b1;
            bus.s_data[0 +: NBIN] = NBIN'(i);
            tick();
        end
        check("full_s_ready0", 64'(bus.s_ready[0]), 64'h0);
        bus.s_data[0 +: NBIN] = NBIN'(5);
        tick();
        tick();
        check("held_s_ready0", 64'(bus.s_ready[0]), 64'h0);

        bus.req_in = 4'b0001;
        exp_in_q.push_back(NBIN'(1));
        tick();
        check("pop_s_ready0", 64'(bus.s_ready[0]), 64'h1);
        exp_in_q.push_back(NBIN'(2));
        tick();
        bus.s_valid = '0;
        for (int i = 3; i <= 5; i++) begin
            exp_in_q.push_back(NBIN'(i));
            tick();
        end
        exp_in_q.push_back(NBIN'(0));
        tick();
        bus.req_in = '0;
        check("uf_ch0", 64'(underflow), 64'h1);
        check("cnt_ch0", 64'(in_cnt[15:0]), 64'(CNT_ON * 5));
        clear_flags();
        check("clr_uf", 64'(underflow), 64'h0);
        check("clr_cnt", 64'(in_cnt[15:0]), 64'h0);

        // Underflow on empty ch2, and event beats clear in the same cycle.
        bus.req_in = 4'b0100;
        exp_in_q.push_back(NBIN'(0));
        tick();
        bus.req_in = '0;
        check("uf_ch2", 64'(underflow), 64'h4);
        bus.req_in = 4'b0100;
        clr_flags = 1'b1;
        exp_in_q.push_back(NBIN'(0));
        tick();
        bus.req_in = '0;
        clr_flags = 1'b0;
        check("uf_set_wins", 64'(underflow), 64'h4);
        clear_flags();
        check("uf_cleared", 64'(underflow), 64'h0);

        // Push and pop together on empty ch1.
        bus.s_valid[1] = 1'b1;
        bus.s_data[NBIN +: NBIN] = NBIN'(7);
        bus.req_in = 4'b0010;
        exp_in_q.push_back(NBIN'(0));
        tick();
        bus.s_valid = '0;
        bus.req_in = '0;
        check("uf_ch1", 64'(underflow), 64'h2);
        bus.req_in = 4'b0010;
        exp_in_q.push_back(NBIN'(7));
        tick();
        bus.req_in = '0;
        clear_flags();
        check("all_ready", 64'(bus.s_ready), 64'hF);

        // Output overwrite without accept.
        bus.out_en = 4'b1000;
        bus.io_out = NBOUT'(100);
        tick();
        bus.out_en = '0;
        check("m_valid_ch3", 64'(bus.m_valid), 64'h8);
        bus.out_en = 4'b1000;
        bus.io_out = NBOUT'(200);
        tick();
        bus.out_en = '0;
        check("ov_ch3", 64'(overflow), 64'h8);
        bus.m_ready[3] = 1'b1;
        exp_out(3, NBOUT'(200));
        tick();
        bus.m_ready = '0;
        check("m_drained", 64'(bus.m_valid), 64'h0);
        clear_flags();

        // Capture while the previous word is accepted: no overflow.
        bus.out_en = 4'b1000;
        bus.io_out = NBOUT'(300);
        tick();
        bus.io_out = NBOUT'(400);
        bus.m_ready[3] = 1'b1;
        exp_out(3, NBOUT'(300));
        tick();
        bus.out_en = '0;
        exp_out(3, NBOUT'(400));
        tick();
        bus.m_ready = '0;
        check("no_ov", 64'(overflow), 64'h0);
        check("m_empty", 64'(bus.m_valid), 64'h0);

        // Multi-bit strobes: no pop, no capture, sel_err.
        bus.s_valid[0] = 1'b1;
        bus.s_data[0 +: NBIN] = NBIN'(9);
        tick();
        bus.s_valid = '0;
        bus.req_in = 4'b0011;
        exp_in_q.push_back(NBIN'(0));
        tick();
        bus.req_in = '0;
        check("sel_err_req", 64'(sel_err), 64'h1);
        check("sel_no_uf", 64'(underflow), 64'h0);
        bus.req_in = 4'b0001;
        exp_in_q.push_back(NBIN'(9));
        tick();
        bus.req_in = '0;
        clear_flags();
        check("sel_cleared", 64'(sel_err), 64'h0);
        bus.out_en = 4'b0011;
        bus.io_out = NBOUT'(55);
        tick();
        bus.out_en = '0;
        check("sel_no_cap", 64'(bus.m_valid), 64'h0);
        check("sel_err_out", 64'(sel_err), 64'h1);
        clear_flags();

        // Reset mid-operation discards FIFO data and pending results.
        bus.s_valid[2] = 1'b1;
        bus.s_data[2*NBIN +: NBIN] = NBIN'(11);
        tick();
        bus.s_valid = '0;
        bus.out_en = 4'b0001;
        bus.io_out = NBOUT'(66);
        tick();
        bus.out_en = '0;
        check("pre_rst_valid", 64'(bus.m_valid), 64'h1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 64'(bus.m_valid), 64'h0);
        check("mid_rst_data", 64'(bus.m_data[63:0]), 64'h0);
        check("mid_rst_ready", 64'(bus.s_ready), 64'hF);
        tick();
        rst_n = 1'b1;
        bus.req_in = 4'b0100;
        exp_in_q.push_back(NBIN'(0));
        tick();
        bus.req_in = '0;
        check("post_rst_uf", 64'(underflow), 64'h4);
        check("post_rst_ov", 64'(overflow), 64'h0);

        tick();
        n_assert++;
        if (exp_in_q.size() != 0 || exp_out_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: in %0d out %0d left, expected 0", exp_in_q.size(), exp_out_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
